fft_mag_sq_frame: RTL and testbench

Downstream consumer of the FFT streaming wrapper output. Takes packed complex bins (re in [15:0], im in [31:16], signed Q1.15) over a valid/ready stream, computes per-bin magnitude squared, marks frame boundaries with tlast every FFT_LEN bins, and reports the peak bin of each frame. Sits between the FFT wrapper master port and the capture/DMA stream returned to the co-simulation host.

---
 rtl/fft_stream_pkg.sv | 20 ++
 rtl/cplx_mag_sq.sv | 66 ++++++
 rtl/fft_mag_sq_frame.sv | 133 +++++++++++++
 tb/tb_fft_mag_sq_frame.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_stream_pkg.sv
// Shared types for the FFT output stream: packed complex bins, magnitude words
// and the per-frame peak tracker states.
package fft_stream_pkg;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] im;
    logic signed [SAMPLE_W-1:0] re;
  } cplx_t;

  typedef logic [31:0] mag_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_LAST  = 2'd2
  } trk_state_e;

endpackage

// File: rtl/cplx_mag_sq.sv
// Two-stage |x|^2 datapath: S1 registers re^2 and im^2, S2 registers their sum.
// Valid and bin index ride alongside; the whole pipe moves only when en is high.
module cplx_mag_sq
  import fft_stream_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  cplx_t            in_data,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output mag_t             out_mag,
  output logic [IDX_W-1:0] out_idx
);

  logic signed [31:0] re_ext_s;
  logic signed [31:0] im_ext_s;
  logic signed [31:0] re_sq_r;
  logic signed [31:0] im_sq_r;
  logic               s1_valid_r;
  logic [IDX_W-1:0]   s1_idx_r;
  logic               s2_valid_r;
  mag_t               s2_mag_r;
  logic [IDX_W-1:0]   s2_idx_r;

  // Widen before squaring so the full 31-bit product is kept.
  assign re_ext_s = {{(32-SAMPLE_W){in_data.re[SAMPLE_W-1]}}, in_data.re};
  assign im_ext_s = {{(32-SAMPLE_W){in_data.im[SAMPLE_W-1]}}, in_data.im};

  // Pipeline registers for both stages plus sideband.
  always_ff @(posedge clk) begin
    if (rst) begin
      re_sq_r    <= 32'sd0;
      im_sq_r    <= 32'sd0;
      s1_valid_r <= 1'b0;
      s1_idx_r   <= {IDX_W{1'b0}};
      s2_valid_r <= 1'b0;
      s2_mag_r   <= 32'd0;
      s2_idx_r   <= {IDX_W{1'b0}};
    end else if (en) begin
      re_sq_r    <= re_ext_s * re_ext_s;
      im_sq_r    <= im_ext_s * im_ext_s;
      s1_valid_r <= in_valid;
      s1_idx_r   <= in_idx;
      s2_valid_r <= s1_valid_r;
      s2_mag_r   <= mag_t'(re_sq_r) + mag_t'(im_sq_r);
      s2_idx_r   <= s1_idx_r;
    end else begin
      re_sq_r    <= re_sq_r;
      im_sq_r    <= im_sq_r;
      s1_valid_r <= s1_valid_r;
      s1_idx_r   <= s1_idx_r;
      s2_valid_r <= s2_valid_r;
      s2_mag_r   <= s2_mag_r;
      s2_idx_r   <= s2_idx_r;
    end
  end

  assign out_valid = s2_valid_r;
  assign out_mag   = s2_mag_r;
  assign out_idx   = s2_idx_r;

endmodule

// File: rtl/fft_mag_sq_frame.sv
// Per-bin magnitude-squared stream with tlast framing every FFT_LEN bins and
// a per-frame peak-bin report.
module fft_mag_sq_frame
  import fft_stream_pkg::*;
#(
  parameter  int FFT_LEN = 64,
  localparam int IDX_W   = $clog2(FFT_LEN)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [31:0]      slave_tdata,
  input  logic             slave_tvalid,
  output logic             slave_tready,
  output logic [31:0]      master_tdata,
  output logic             master_tvalid,
  input  logic             master_tready,
  output logic             master_tlast,
  output logic [IDX_W-1:0] peak_bin,
  output logic [31:0]      peak_mag,
  output logic             peak_valid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);

  logic             en_s, accept_s, hs_s, is_last_s, load_peak_s;
  logic             out_valid_s;
  mag_t             out_mag_s;
  logic [IDX_W-1:0] out_idx_s;
  logic [IDX_W-1:0] bin_cnt_r;
  mag_t             run_max_r, max_next_s, peak_mag_r;
  logic [IDX_W-1:0] run_bin_r, bin_next_s, peak_bin_r;
  logic             peak_valid_r;
  trk_state_e       state_r, state_next_s;

  // No skid buffer: input is accepted only when the output register can move.
  assign en_s         = !out_valid_s || master_tready;
  assign slave_tready = en_s && !areset;
  assign accept_s     = slave_tvalid && slave_tready;
  assign hs_s         = out_valid_s && master_tready;
  assign is_last_s    = (out_idx_s == LAST_IDX);

  cplx_mag_sq #(.IDX_W(IDX_W)) u_mag (
    .clk      (aclk),
    .rst      (areset),
    .en       (en_s),
    .in_valid (accept_s),
    .in_data  (cplx_t'(slave_tdata)),
    .in_idx   (bin_cnt_r),
    .out_valid(out_valid_s),
    .out_mag  (out_mag_s),
    .out_idx  (out_idx_s)
  );

  // Bin index of the next accepted input beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      bin_cnt_r <= {IDX_W{1'b0}};
    end else if (accept_s) begin
      bin_cnt_r <= (bin_cnt_r == LAST_IDX) ? {IDX_W{1'b0}} : bin_cnt_r + IDX_W'(1);
    end else begin
      bin_cnt_r <= bin_cnt_r;
    end
  end

  // Tracker next state; LAST is entered only on the tlast handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) state_next_s = is_last_s ? ST_LAST : ST_ACCUM;
        else      state_next_s = ST_IDLE;
      end
      ST_ACCUM: begin
        if (hs_s && is_last_s) state_next_s = ST_LAST;
        else                   state_next_s = ST_ACCUM;
      end
      ST_LAST: begin
        if (hs_s) state_next_s = ST_ACCUM;
        else      state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
    load_peak_s = (state_next_s == ST_LAST);
  end

  // Running max: bin 0 always loads, later bins only on a strict increase.
  always_comb begin
    max_next_s = run_max_r;
    bin_next_s = run_bin_r;
    if (hs_s && (out_idx_s == {IDX_W{1'b0}})) begin
      max_next_s = out_mag_s;
      bin_next_s = out_idx_s;
    end else if (hs_s && (out_mag_s > run_max_r)) begin
      max_next_s = out_mag_s;
      bin_next_s = out_idx_s;
    end else begin
      max_next_s = run_max_r;
      bin_next_s = run_bin_r;
    end
  end

  // Tracker state, running max and the published per-frame peak.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r      <= ST_IDLE;
      run_max_r    <= 32'd0;
      run_bin_r    <= {IDX_W{1'b0}};
      peak_mag_r   <= 32'd0;
      peak_bin_r   <= {IDX_W{1'b0}};
      peak_valid_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      run_max_r    <= max_next_s;
      run_bin_r    <= bin_next_s;
      peak_valid_r <= load_peak_s;
      if (load_peak_s) begin
        peak_mag_r <= max_next_s;
        peak_bin_r <= bin_next_s;
      end else begin
        peak_mag_r <= peak_mag_r;
        peak_bin_r <= peak_bin_r;
      end
    end
  end

  assign master_tvalid = out_valid_s;
  assign master_tdata  = out_mag_s;
  assign master_tlast  = out_valid_s && is_last_s;
  assign peak_bin      = peak_bin_r;
  assign peak_mag      = peak_mag_r;
  assign peak_valid    = peak_valid_r;

endmodule

// File: tb/tb_fft_mag_sq_frame.sv
// Directed + randomized bench for fft_mag_sq_frame (FFT_LEN=8) with a
// scoreboard of expected beats and frame peaks.
module tb_fft_mag_sq_frame;

  localparam int N = 8;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] slave_tdata;
  logic        slave_tvalid;
  logic        slave_tready;
  logic [31:0] master_tdata;
  logic        master_tvalid;
  logic        master_tready;
  logic        master_tlast;
  logic [2:0]  peak_bin;
  logic [31:0] peak_mag;
  logic        peak_valid;

  always #5 aclk = ~aclk;

  fft_mag_sq_frame #(.FFT_LEN(N)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .slave_tdata  (slave_tdata),
    .slave_tvalid (slave_tvalid),
    .slave_tready (slave_tready),
    .master_tdata (master_tdata),
    .master_tvalid(master_tvalid),
    .master_tready(master_tready),
    .master_tlast (master_tlast),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .peak_valid   (peak_valid)
  );

  int          tests = 0;
  int          fails = 0;
  logic [32:0] sb_q[$];
  logic [34:0] pk_q[$];
  int          m_idx = 0;
  logic [31:0] m_max = 32'd0;
  logic [2:0]  m_bin = 3'd0;
  int          pulses = 0;
  int          exp_pulses = 0;
  bit          rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mag_of(input int re, input int im);
    longint r = re;
    longint i = im;
    longint s = r * r + i * i;
    return s[31:0];
  endfunction

  task automatic model_push(input int re, input int im);
    logic [31:0] m = mag_of(re, im);
    logic last = (m_idx == N - 1);
    sb_q.push_back({last, m});
    if (m_idx == 0 || m > m_max) begin
      m_max = m;
      m_bin = 3'(m_idx);
    end
    if (last) begin
      pk_q.push_back({m_bin, m_max});
      exp_pulses++;
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int re, input int im, input int gap);
    repeat (gap) begin
      slave_tvalid = 1'b0;
      @(posedge aclk); #1;
    end
    slave_tdata  = {16'(im), 16'(re)};
    slave_tvalid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge aclk);
      if (slave_tready) begin
        model_push(re, im);
        @(posedge aclk); #1;
        slave_tvalid = 1'b0;
        return;
      end
    end
    check("send_accept", {63'd0, slave_tready}, 64'd1);
    slave_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      @(negedge aclk);
      if (sb_q.size() == 0 && !master_tvalid) break;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
    repeat (2) @(negedge aclk);
    @(posedge aclk); #1;
  endtask

  initial begin
    logic signed [15:0] r_re, r_im;
    int tie_re [8] = '{1, 2, 3, 10, 0, 6, -8, 1};
    int tie_im [8] = '{1, 0, 0, 0, 9, 8, -6, 0};
    int pulses_before;

    areset        = 1'b1;
    slave_tvalid  = 1'b1;
    slave_tdata   = 32'd0;
    master_tready = 1'b1;

    fork
      begin : monitor
        bit          prev_stall = 1'b0;
        logic [31:0] prev_data  = 32'd0;
        logic        prev_last  = 1'b0;
        logic [32:0] e;
        logic [34:0] pe;
        forever begin
          @(negedge aclk);
          if (areset) begin
            prev_stall = 1'b0;
          end else begin
            if (prev_stall) begin
              check("hold_valid", {63'd0, master_tvalid}, 64'd1);
              check("hold_data", {32'd0, master_tdata}, {32'd0, prev_data});
              check("hold_last", {63'd0, master_tlast}, {63'd0, prev_last});
            end
            if (master_tvalid && master_tready) begin
              if (sb_q.size() == 0) begin
                check("extra_beat", {63'd0, master_tvalid}, 64'd0);
              end else begin
                e = sb_q.pop_front();
                check("tdata", {32'd0, master_tdata}, {32'd0, e[31:0]});
                check("tlast", {63'd0, master_tlast}, {63'd0, e[32]});
              end
            end
            prev_stall = master_tvalid && !master_tready;
            prev_data  = master_tdata;
            prev_last  = master_tlast;
            if (peak_valid) begin
              pulses++;
              if (pk_q.size() == 0) begin
                check("extra_peak", {63'd0, peak_valid}, 64'd0);
              end else begin
                pe = pk_q.pop_front();
                check("peak_bin", {61'd0, peak_bin}, {61'd0, pe[34:32]});
                check("peak_mag", {32'd0, peak_mag}, {32'd0, pe[31:0]});
              end
            end
          end
        end
      end
      begin : ready_gen
        forever begin
          @(posedge aclk); #1;
          if (rand_ready) master_tready = 1'($urandom_range(0, 1));
        end
      end
    join_none

    // Reset held three cycles with a beat offered.
    repeat (3) begin
      @(negedge aclk);
      check("rst_tready", {63'd0, slave_tready}, 64'd0);
      check("rst_tvalid", {63'd0, master_tvalid}, 64'd0);
      check("rst_tdata", {32'd0, master_tdata}, 64'd0);
      check("rst_tlast", {63'd0, master_tlast}, 64'd0);
      check("rst_pvalid", {63'd0, peak_valid}, 64'd0);
      check("rst_pbin", {61'd0, peak_bin}, 64'd0);
      check("rst_pmag", {32'd0, peak_mag}, 64'd0);
    end
    areset = 1'b0;
    #1;
    check("post_rst_tready", {63'd0, slave_tready}, 64'd1);
    model_push(0, 0);
    @(posedge aclk); #1;
    slave_tvalid = 1'b0;

    // Single frame: bin k = (k, -k).
    for (int k = 1; k < N; k++) send(k, -k, 0);
    drain();
    check("frame1_pbin", {61'd0, peak_bin}, 64'd7);
    check("frame1_pmag", {32'd0, peak_mag}, 64'd98);
    check("frame1_pulses", 64'(pulses), 64'd1);

    // Extremes, with a 2-cycle latency check on the first beat.
    send(-32768, -32768, 2);
    @(negedge aclk);
    check("lat1_valid", {63'd0, master_tvalid}, 64'd0);
    @(negedge aclk);
    check("lat2_valid", {63'd0, master_tvalid}, 64'd1);
    check("ext_min", {32'd0, master_tdata}, 64'h80000000);
    @(posedge aclk); #1;
    send(32767, 0, 0);
    for (int k = 2; k < N; k++) send(k, k, 0);
    drain();
    check("ext_pbin", {61'd0, peak_bin}, 64'd0);
    check("ext_pmag", {32'd0, peak_mag}, 64'h80000000);

    // Tie at magnitude 100: lowest index wins.
    for (int k = 0; k < N; k++) send(tie_re[k], tie_im[k], 0);
    drain();
    check("tie_pbin", {61'd0, peak_bin}, 64'd3);
    check("tie_pmag", {32'd0, peak_mag}, 64'd100);

    // Backpressure and input gaps over four random frames.
    rand_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < N; k++) begin
        r_re = 16'($urandom);
        r_im = 16'($urandom);
        send(int'(r_re), int'(r_im), $urandom_range(0, 2));
      end
    end
    rand_ready = 1'b0;
    @(posedge aclk); #1;
    master_tready = 1'b1;
    drain();
    check("bp_pulses", 64'(pulses), 64'(exp_pulses));

    // Reset after bin 4 of a frame, then a full frame.
    for (int k = 0; k < 5; k++) send(k, 2 * k, 0);
    pulses_before = pulses;
    areset = 1'b1;
    @(posedge aclk); #1;
    sb_q.delete();
    m_idx  = 0;
    areset = 1'b0;
    repeat (3) @(negedge aclk);
    check("mid_no_peak", 64'(pulses), 64'(pulses_before));
    check("mid_no_tvalid", {63'd0, master_tvalid}, 64'd0);
    @(posedge aclk); #1;
    for (int k = 0; k < N; k++) send(3 * k, 1, 0);
    drain();
    check("mid_pulses", 64'(pulses), 64'(pulses_before + 1));
    check("mid_pbin", {61'd0, peak_bin}, 64'd7);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("pk_empty", 64'(pk_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
